mem_port_arbiter: RTL

//  Shares the single program/data memory port between the instruction-fetch requester (IF stage)
//  and the load/store requester (MEM stage). Supports one outstanding access at a time.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared types for the cpu memory-port logic.
//   arb_state_t : sequencing states of the memory-port arbiter
//   arb_owner_t : which requester currently owns the memory port
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } arb_owner_t;

endpackage : cpu_pkg

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single program/data memory port between instruction fetch (IF)
//   and load/store (LS). One access is outstanding at a time, sequenced as
//   grant (IDLE) -> issue (ISSUE) -> latency wait (WAIT) -> response (RESP).
//   Load/store wins arbitration, except that a fetch which has lost MAX_WAIT
//   consecutive arbitrations is granted next.
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   if_req/if_addr            fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, data-valid pulse, data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be            load/store request, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata load/store grant pulse, valid/ack pulse, data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_be          memory access strobe and registered command
//   mem_rdata                 memory read data, valid MEM_LAT cycles after mem_en
//   busy                      high whenever an access is in flight
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int CNT_W  = $clog2(MEM_LAT + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q;
  logic [CNT_W-1:0]    lat_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                grant_if, grant_ls;
  logic                starved;
  logic                last_wait;

  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_be_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

  assign starved   = (wait_cnt_q == WAIT_W'(MAX_WAIT));
  assign last_wait = (state_q == ARB_WAIT) && (lat_cnt_q == CNT_W'(1));

  // Arbitration, starvation tracking and next-state logic.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // No grant while reset is asserted: the state register would not
        // advance, so the requester would see a grant that never completes.
        if (rst) begin
          if (ls_req && !(if_req && starved)) begin
            grant_ls = 1'b1;
            state_d  = ARB_ISSUE;
            // A losing fetch here implies !starved, so this never passes MAX_WAIT.
            if (if_req && !starved) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end else if (if_req) begin
            grant_if   = 1'b1;
            state_d    = ARB_ISSUE;
            wait_cnt_d = '0;
          end
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (last_wait) state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // sampled on the clock edge, so every register here clears synchronously.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;

      // Command is captured at grant and held until the next grant.
      if (grant_ls) begin
        owner_q     <= OWN_LS;
        mem_we_q    <= ls_we;
        mem_addr_q  <= ls_addr;
        mem_wdata_q <= ls_we ? ls_wdata : '0;
        mem_be_q    <= ls_we ? ls_be : '1;
      end else if (grant_if) begin
        owner_q     <= OWN_IF;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
      end else if (state_q == ARB_RESP) begin
        owner_q     <= OWN_NONE;
      end

      if (state_q == ARB_ISSUE) begin
        lat_cnt_q <= CNT_W'(MEM_LAT);
      end else if (state_q == ARB_WAIT) begin
        lat_cnt_q <= lat_cnt_q - CNT_W'(1);
      end

      // Read data goes straight into the owner's output register, so it
      // appears with rvalid in RESP and holds until that owner's next RESP.
      if (last_wait) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= mem_rdata;
        end else if (owner_q == OWN_LS) begin
          ls_rdata_q <= mem_we_q ? '0 : mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign if_rvalid = (state_q == ARB_RESP) && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == ARB_RESP) && (owner_q == OWN_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

  assign mem_en    = (state_q == ARB_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  assign busy      = (state_q != ARB_IDLE);

  // Fetch addresses must be halfword aligned.
  a_if_addr_aligned : assert property (
    @(posedge clk) disable iff (!rst) if_req |-> !if_addr[0]
  );

endmodule : mem_port_arbiter
